// File: rtl/add_eight_serial_pkg.sv
// add_eight_serial_pkg
// Shared definitions for the bit-serial adder: the operand/result width,
// the three sequencing states and a helper that sizes the bit counter.
// No ports; imported by the interface, the top and the full-adder cell.

package add_eight_serial_pkg;

    // Operand and result width. Only 8 is exercised, but the sequencing
    // logic is written in terms of this value.
    localparam int WIDTH = 8;

    // Sequencing states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that must index every bit of a WIDTH-bit operand.
    // Never returns 0 so a degenerate WIDTH=1 still yields a legal vector.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/add_eight_serial_if.sv
// add_eight_serial_if
// Groups the request/response signals of the serial adder.
//   start   : request an add (sampled only while the adder is idle)
//   d0, d1  : addends, captured on the accepting edge
//   enable  : output gate for dOut
//   busy    : adder is working or presenting a completion
//   done    : one-cycle completion pulse
//   dOut    : last completed sum, gated by enable
//   cOut    : carry out of the most significant bit of the last sum
// master modport is the requester, slave modport is the adder.

interface add_eight_serial_if #(
    parameter int WIDTH = add_eight_serial_pkg::WIDTH
);

    logic             start;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             enable;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dOut;
    logic             cOut;

    modport master (
        output start, d0, d1, enable,
        input  busy, done, dOut, cOut
    );

    modport slave (
        input  start, d0, d1, enable,
        output busy, done, dOut, cOut
    );

endinterface

// File: rtl/add_eight_serial_full_adder_cell.sv
// full_adder_cell
// One-bit full adder used by the serial adder for each bit position.
//   a, b : operand bits
//   cIn  : carry in
//   sum  : sum bit
//   cOut : carry out

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cIn,
    output logic sum,
    output logic cOut
);

    import add_eight_serial_pkg::*;

    // Plain sum-of-products full adder; purely combinational.
    always_comb begin
        sum  = a ^ b ^ cIn;
        cOut = (a & b) | (a & cIn) | (b & cIn);
    end

endmodule

// File: rtl/add_eight_serial.sv
// add_eight_serial
// Bit-serial adder: captures two WIDTH-bit addends on start, adds them one
// bit per clock (LSB first) through a single full-adder cell, and publishes
// the sum and carry together on the edge that processes the last bit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of add_eight_serial_if (start/d0/d1/enable in,
//           busy/done/dOut/cOut out)

module add_eight_serial #(
    parameter int WIDTH = add_eight_serial_pkg::WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    add_eight_serial_if.slave   bus
);

    import add_eight_serial_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    // Partial sum collected so far; the final bit goes straight into
    // result, so one bit fewer than the operand width is enough.
    logic [WIDTH-2:0]   work_q,   work_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               fa_sum;
    logic               fa_cout;

    // The single arithmetic cell; operands are consumed from the LSB end
    // of the shift registers.
    full_adder_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cIn  (carry_q),
        .sum  (fa_sum),
        .cOut (fa_cout)
    );

    // Next-state logic. result/cout only change on the last RUN edge so the
    // previous sum stays visible while a new add is in progress. start is
    // only looked at in IDLE, so requests during RUN/DONE are dropped.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        carry_d  = carry_q;
        count_d  = count_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.d0;
                    b_d     = bus.d1;
                    carry_d = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                work_d  = {fa_sum, work_q[WIDTH-2:1]};
                carry_d = fa_cout;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
                    result_d = {fa_sum, work_q};
                    cout_d   = fa_cout;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the registered busy/done outputs, lives in this
    // one block so a reset aborts any add in progress without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // enable gates only the visible sum; the stored result is untouched so
    // raising enable again shows it without a new add.
    always_comb begin
        bus.busy = busy_q;
        bus.done = done_q;
        bus.dOut = result_q & {WIDTH{bus.enable}};
        bus.cOut = cout_q;
    end

endmodule

// File: tb/tb_add_eight_serial.sv
// tb_add_eight_serial
// Self-checking bench for add_eight_serial: directed cases plus randomized
// adds compared against an arithmetic reference (A+B, wrap and carry).

module tb_add_eight_serial;

    logic clk;
    logic rst_n;

    add_eight_serial_if bus_if ();

    add_eight_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int testCount = 0;
    int failCount = 0;

    // Reference state: the last completed result the adder should show.
    logic [7:0] expResult = 8'h00;
    logic       expCarry  = 1'b0;

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One full add from IDLE. mode 0: quiet inputs during the add,
    // mode 1: d0/d1 forced to AA after acceptance, mode 2: random d0/d1
    // and random start pulses during the add (must be ignored).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic en, input int mode);
        logic [8:0] full;
        logic [7:0] newSum;
        logic       newCarry;
        int         busyCycles;
        full     = {1'b0, a} + {1'b0, b};
        newSum   = full[7:0];
        newCarry = full[8];
        busyCycles = 0;

        @(negedge clk);
        bus_if.d0     = a;
        bus_if.d1     = b;
        bus_if.enable = en;
        bus_if.start  = 1'b1;
        @(posedge clk);

        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (bus_if.busy === 1'b1) busyCycles++;
            checkOutput("busy_in_add", bus_if.busy, 1);
            checkOutput("done_in_add", bus_if.done, (k == 8) ? 1 : 0);
            if (k < 8) begin
                checkOutput("dout_hold", bus_if.dOut, en ? expResult : 8'h00);
                checkOutput("cout_hold", bus_if.cOut, expCarry);
            end else begin
                checkOutput("dout_result", bus_if.dOut, en ? newSum : 8'h00);
                checkOutput("cout_result", bus_if.cOut, newCarry);
            end
            bus_if.start = 1'b0;
            if (mode == 1) begin
                bus_if.d0 = 8'hAA;
                bus_if.d1 = 8'hAA;
            end else if (mode == 2) begin
                bus_if.d0    = 8'($urandom);
                bus_if.d1    = 8'($urandom);
                bus_if.start = 1'($urandom);
            end
        end

        @(negedge clk);
        bus_if.start = 1'b0;
        checkOutput("busy_after", bus_if.busy, 0);
        checkOutput("done_after", bus_if.done, 0);
        checkOutput("dout_after", bus_if.dOut, en ? newSum : 8'h00);
        checkOutput("busy_cycles", busyCycles, 9);

        expResult = newSum;
        expCarry  = newCarry;
    endtask

    initial begin
        int donePulses;

        rst_n         = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.d0     = 8'h00;
        bus_if.d1     = 8'h00;
        bus_if.enable = 1'b1;

        // Reset state before any clock edge.
        #3;
        checkOutput("rst_busy", bus_if.busy, 0);
        checkOutput("rst_done", bus_if.done, 0);
        checkOutput("rst_dout", bus_if.dOut, 8'h00);
        checkOutput("rst_cout", bus_if.cOut, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add and carry/wrap boundaries.
        applyStimulus(8'h12, 8'h34, 1'b1, 0);
        applyStimulus(8'hFF, 8'h01, 1'b1, 0);
        applyStimulus(8'h80, 8'h80, 1'b1, 0);

        // Operand changes after acceptance must not matter.
        applyStimulus(8'h0F, 8'h01, 1'b1, 1);

        // enable low at completion, then raised with no new start.
        applyStimulus(8'h7F, 8'h01, 1'b0, 0);
        bus_if.enable = 1'b1;
        #1;
        checkOutput("enable_raise", bus_if.dOut, 8'h80);

        // start held high: one acceptance per 10-cycle period.
        @(negedge clk);
        bus_if.d0    = 8'h01;
        bus_if.d1    = 8'h01;
        bus_if.start = 1'b1;
        donePulses   = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.done === 1'b1) donePulses++;
            checkOutput("held_done", bus_if.done, ((i % 10) == 8) ? 1 : 0);
            checkOutput("held_busy", bus_if.busy, ((i % 10) == 9) ? 0 : 1);
        end
        bus_if.start = 1'b0;
        checkOutput("held_pulses", donePulses, 3);
        checkOutput("held_dout", bus_if.dOut, 8'h02);
        expResult = 8'h02;
        expCarry  = 1'b0;

        // Reset in the 4th RUN cycle aborts with no done pulse.
        @(negedge clk);
        bus_if.d0    = 8'hC3;
        bus_if.d1    = 8'h5A;
        bus_if.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", bus_if.busy, 0);
        checkOutput("abort_done", bus_if.done, 0);
        checkOutput("abort_dout", bus_if.dOut, 8'h00);
        checkOutput("abort_cout", bus_if.cOut, 0);
        donePulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (bus_if.done === 1'b1) donePulses++;
        end
        checkOutput("abort_no_done", donePulses, 0);
        expResult = 8'h00;
        expCarry  = 1'b0;
        applyStimulus(8'h05, 8'h03, 1'b1, 0);

        // Randomized adds with random gating and input noise.
        for (int n = 0; n < 25; n++) begin
            applyStimulus(8'($urandom), 8'($urandom),
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 1) == 1) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
